cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares NUM_CDB common-data-bus broadcast slots among NUM_REQ functional-unit result queues (ALU, mul, br, mem).
//  Each cycle it picks up to NUM_CDB non-empty queues, pops each one, and broadcasts the entries on registered CDB ports.
//  The ROB, reservation stations and RAT/PRF snoop these ports.
//  Arbitration is round-robin, with a starvation override for any queue that has waited too long.
// PARAMETERS
//  NUM_REQ       4  number of requesting FU queues (index 0..NUM_REQ-1)
//  NUM_CDB       2  broadcast slots per cycle; NUM_CDB <= NUM_REQ
//  STARVE_LIMIT  8  consecutive lost cycles after which a requester becomes urgent
// PORTS
//  clk        in   1                   clock
//  rst        in   1                   reset, synchronous, active-high
//  flush      in   1                   mispredict squash from ROB
//  req_entry  in   cdb_entry_t[NUM_REQ] head entry of each FU queue; req_entry[i].valid = queue i non-empty
//  dequeue    out  NUM_REQ             pop strobe to queue i (combinational, same cycle as grant)
//  cdb_out    out  cdb_entry_t[NUM_CDB] registered broadcast entries
//  grant_idx  out  NUM_CDB*$clog2(NUM_REQ)  registered source index per slot (debug/ROB)
// BEHAVIOUR
//  - Reset: cdb_out[k].valid=0, all other cdb_out fields 0, grant_idx=0, rr_ptr=0, all starve_cnt=0. dequeue=0 while rst is high.
//  - Latency: queue i granted in cycle N -> dequeue[i]=1 in N -> entry on cdb_out in N+1 with valid=1.
//    A slot not filled in N has cdb_out[k].valid=0 in N+1.
//  - Eligibility: req i is eligible iff req_entry[i].valid and flush=0.
//  - Urgent set: eligible i with starve_cnt[i]==STARVE_LIMIT.
//  - Slot fill order, for k=0..NUM_CDB-1, never granting one requester twice:
//    1) lowest-index ungranted urgent requester;
//    2) otherwise the first ungranted eligible requester scanning from rr_ptr upward with wrap mod NUM_REQ.
//  - dequeue[i]=1 iff i granted in any slot. cdb_out[k] <= req_entry[granted]; grant_idx[k] <= granted.
//  - rr_ptr: any grant -> rr_ptr <= (highest-slot non-urgent grant index + 1) mod NUM_REQ.
//    If all grants were urgent, or there was no grant, rr_ptr is unchanged.
//  - starve_cnt[i]: cleared on grant; +1 (saturating at STARVE_LIMIT) when eligible and not granted; held when not eligible.
//    Width $clog2(STARVE_LIMIT+1).
//  - Flush in cycle N:
//    - no dequeues in N;
//    - all cdb_out valid=0 in N+1;
//    - rr_ptr and starve_cnt cleared.
//    Queues are flushed by their owners.
//  - More eligible requesters than slots: losers keep their entries (no dequeue) and retry next cycle.
//  - Fewer eligible requesters than slots: unused slots are invalid. Grants pack into the lowest slots.
//  - rst has priority over flush. Reset mid-stream discards in-flight cdb_out contents with no broadcast.
//  - No back-pressure: CDB consumers always accept.
// STRUCTURE
//  - rv32i_types package holds:
//    - cdb_entry_t (existing);
//    - localparams NUM_CDB and NUM_FU_QUEUES;
//    - FU index constants FU_ALU0/FU_MUL/FU_BR/FU_MEM.
//  - One sub-module, rr_pick #(N): given an eligible mask, an already-granted mask and a start pointer,
//    returns a one-hot pick plus a found bit. It is instantiated once per slot and chained so each stage
//    masks earlier grants. The urgent path reuses it with start=0.
//  - rr_ptr, starve_cnt and the output registers live in the top level.
// TESTING
//  1. Reset then idle: all req valid=0 -> dequeue=0, cdb_out[0].valid=cdb_out[1].valid=0 for 10 cycles.
//  2. Two requesters: req 1 and 3 valid, rr_ptr=0 -> dequeue=4'b1010 in N; in N+1 cdb_out[0]=req1 entry,
//     cdb_out[1]=req3 entry, grant_idx={3,1}, rr_ptr=0.
//  3. Rotation: all 4 valid continuously -> grants {0,1},{2,3},{0,1},... and each queue is popped every 2nd cycle.
//  4. Starvation: STARVE_LIMIT=2, NUM_CDB=1; req0 and req1 always valid, req2 valid.
//     Every requester is granted within 3 cycles. Force a starve_cnt[2]=2 case -> req2 wins the slot
//     ahead of the rr_ptr candidate, and rr_ptr is unchanged.
//  5. Flush: all valid, flush=1 in N -> dequeue=0 in N, cdb_out valid all 0 in N+1, rr_ptr=0 and starve_cnt=0 after N.
//  6. Reset mid-stream: rst=1 with grants pending -> N+1 outputs match the reset values.
//     Holding rst and flush together gives the reset behaviour.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared core types: CDB broadcast entry, FU queue indices and CDB sizing.
package rv32i_types;

    localparam int unsigned NUM_FU_QUEUES = 4;
    localparam int unsigned NUM_CDB       = 2;

    localparam int unsigned FU_ALU0 = 0;
    localparam int unsigned FU_MUL  = 1;
    localparam int unsigned FU_BR   = 2;
    localparam int unsigned FU_MEM  = 3;

    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned PREG_W    = 6;
    localparam int unsigned AREG_W    = 5;
    localparam int unsigned XLEN      = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd;
        logic [AREG_W-1:0]    rd;
        logic [XLEN-1:0]      data;
    } cdb_entry_t;

    // Index width that stays legal for a single-entry range.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-queue / CDB bundle between the result queues and the CDB arbiter.
interface cdb_arbiter_if
    import rv32i_types::*;
#(
    parameter int unsigned NUM_REQ = NUM_FU_QUEUES,
    parameter int unsigned NUM_CDB = rv32i_types::NUM_CDB
);
    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    logic                             flush;
    cdb_entry_t [NUM_REQ-1:0]         req_entry;
    logic       [NUM_REQ-1:0]         dequeue;
    cdb_entry_t [NUM_CDB-1:0]         cdb_out;
    logic       [NUM_CDB*IDX_W-1:0]   grant_idx;

    modport master (
        output flush,
        output req_entry,
        input  dequeue,
        input  cdb_out,
        input  grant_idx
    );

    modport slave (
        input  flush,
        input  req_entry,
        output dequeue,
        output cdb_out,
        output grant_idx
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// One-hot pick of the first eligible, not-yet-granted requester scanning from start with wrap.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [N-1:0]  granted,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  pick,
    output logic          found
);

    logic [IW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < int'(N); off++) begin
            idx = IW'((int'(start) + off) % int'(N));
            if (!found && eligible[idx] && !granted[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with starvation override: fills up to NUM_CDB broadcast
// slots per cycle from the FU result queues and registers the winners onto the CDB.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned NUM_REQ      = NUM_FU_QUEUES,
    parameter int unsigned NUM_CDB      = rv32i_types::NUM_CDB,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [IDX_W-1:0]                rr_ptr;
    logic [IDX_W-1:0]                rr_ptr_nxt;
    logic [CNT_W-1:0]                starve_cnt [NUM_REQ];

    logic [NUM_REQ-1:0]              eligible;
    logic [NUM_REQ-1:0]              urgent;
    logic [NUM_REQ-1:0]              grant_mask;
    logic [NUM_CDB-1:0][NUM_REQ-1:0] slot_pick;
    logic [NUM_CDB-1:0][IDX_W-1:0]   slot_idx;
    logic [NUM_CDB-1:0]              slot_valid;
    logic [NUM_CDB-1:0]              slot_urgent;

    always_comb begin
        eligible = '0;
        urgent   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            eligible[i] = bus.req_entry[i].valid & ~bus.flush;
            urgent[i]   = eligible[i] && (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Each slot masks the grants of all lower slots; urgent requesters pre-empt round-robin.
    for (genvar k = 0; k < int'(NUM_CDB); k++) begin : g_slot
        logic [NUM_REQ-1:0] taken_in;
        logic [NUM_REQ-1:0] taken_out;
        logic [NUM_REQ-1:0] urg_oh;
        logic [NUM_REQ-1:0] rr_oh;
        logic               urg_found;
        logic               rr_found;

        if (k == 0) begin : g_first
            assign taken_in = '0;
        end else begin : g_next
            assign taken_in = g_slot[k-1].taken_out;
        end

        rr_pick #(.N(NUM_REQ)) u_urg_pick (
            .eligible (urgent),
            .granted  (taken_in),
            .start    (IDX_W'(0)),
            .pick     (urg_oh),
            .found    (urg_found)
        );

        rr_pick #(.N(NUM_REQ)) u_rr_pick (
            .eligible (eligible),
            .granted  (taken_in),
            .start    (rr_ptr),
            .pick     (rr_oh),
            .found    (rr_found)
        );

        assign slot_pick[k]   = urg_found ? urg_oh : rr_oh;
        assign slot_valid[k]  = urg_found | rr_found;
        assign slot_urgent[k] = urg_found;
        assign taken_out      = taken_in | slot_pick[k];
    end

    always_comb begin
        grant_mask = '0;
        slot_idx   = '0;
        for (int k = 0; k < int'(NUM_CDB); k++) begin
            grant_mask = grant_mask | slot_pick[k];
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (slot_pick[k][i]) begin
                    slot_idx[k] = IDX_W'(i);
                end
            end
        end
    end

    // Highest-slot non-urgent grant sets the next round-robin start.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        for (int k = 0; k < int'(NUM_CDB); k++) begin
            if (slot_valid[k] && !slot_urgent[k]) begin
                rr_ptr_nxt = (slot_idx[k] == IDX_W'(NUM_REQ - 1)) ? '0 : slot_idx[k] + IDX_W'(1);
            end
        end
        if (bus.flush) begin
            rr_ptr_nxt = '0;
        end
    end

    assign bus.dequeue = rst ? '0 : grant_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            bus.cdb_out   <= '0;
            bus.grant_idx <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            rr_ptr <= rr_ptr_nxt;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (bus.flush || grant_mask[i]) begin
                    starve_cnt[i] <= '0;
                end else if (eligible[i] && (starve_cnt[i] != CNT_W'(STARVE_LIMIT))) begin
                    starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
                end
            end
            for (int k = 0; k < int'(NUM_CDB); k++) begin
                if (slot_valid[k]) begin
                    bus.cdb_out[k]                     <= bus.req_entry[slot_idx[k]];
                    bus.grant_idx[k*IDX_W +: IDX_W]    <= slot_idx[k];
                end else begin
                    bus.cdb_out[k]                     <= '0;
                    bus.grant_idx[k*IDX_W +: IDX_W]    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed checks of the CDB arbiter: main 2-slot instance plus a 1-slot, short-starve instance.
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(4), .NUM_CDB(2)) bus ();
    cdb_arbiter_if #(.NUM_REQ(4), .NUM_CDB(1)) sbus ();

    cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(2), .STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(1), .STARVE_LIMIT(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    function automatic cdb_entry_t mk(input int i, input int tag);
        cdb_entry_t e;
        e         = '0;
        e.valid   = 1'b1;
        e.rob_idx = 5'(i + 4 * tag);
        e.pd      = 6'(8 * i + tag);
        e.rd      = 5'(i + 1);
        e.data    = 32'hC0DE_0000 | 32'(tag << 4) | 32'(i);
        return e;
    endfunction

    task automatic drive(input logic [3:0] v, input int tag);
        for (int i = 0; i < 4; i++) begin
            bus.req_entry[i] = v[i] ? mk(i, tag) : '0;
        end
    endtask

    task automatic drive_s(input logic [3:0] v, input int tag);
        for (int i = 0; i < 4; i++) begin
            sbus.req_entry[i] = v[i] ? mk(i, tag) : '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1111, 9);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.dequeue !== 4'b0000) begin
            errors++; $display("FAIL reset_dequeue got %b exp 0000", bus.dequeue);
        end
        checks++;
        if (bus.cdb_out !== '0) begin
            errors++; $display("FAIL reset_cdb_out got %h exp 0", bus.cdb_out);
        end
        checks++;
        if (bus.grant_idx !== 4'b0000 || dut.rr_ptr !== 2'd0) begin
            errors++; $display("FAIL reset_ptr got grant_idx %b rr_ptr %0d exp 0 0", bus.grant_idx, dut.rr_ptr);
        end
        @(negedge clk);
        drive(4'b0000, 0);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (bus.dequeue !== 4'b0000) begin
                errors++; $display("FAIL idle_dequeue cyc %0d got %b exp 0000", c, bus.dequeue);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.cdb_out[0].valid !== 1'b0 || bus.cdb_out[1].valid !== 1'b0) begin
                errors++; $display("FAIL idle_valid cyc %0d got %b%b exp 00", c,
                                   bus.cdb_out[1].valid, bus.cdb_out[0].valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_two();
        drive(4'b1010, 1);
        #1;
        checks++;
        if (bus.dequeue !== 4'b1010) begin
            errors++; $display("FAIL two_dequeue got %b exp 1010", bus.dequeue);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cdb_out[0] !== mk(1, 1) || bus.cdb_out[1] !== mk(3, 1)) begin
            errors++; $display("FAIL two_cdb got %h %h exp %h %h", bus.cdb_out[0], bus.cdb_out[1], mk(1, 1), mk(3, 1));
        end
        checks++;
        if (bus.grant_idx !== 4'b1101 || dut.rr_ptr !== 2'd0) begin
            errors++; $display("FAIL two_idx got %b rr %0d exp 1101 0", bus.grant_idx, dut.rr_ptr);
        end
        @(negedge clk);
        drive(4'b0000, 0);
        @(posedge clk); #1;
        checks++;
        if (bus.cdb_out[0].valid !== 1'b0 || bus.cdb_out[1].valid !== 1'b0) begin
            errors++; $display("FAIL two_drain got %b%b exp 00", bus.cdb_out[1].valid, bus.cdb_out[0].valid);
        end
        @(negedge clk);
    endtask

    task automatic test_rotation();
        logic [3:0] exp_deq;
        logic [3:0] exp_idx;
        for (int c = 0; c < 6; c++) begin
            exp_deq = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            exp_idx = (c % 2 == 0) ? 4'b0100 : 4'b1110;
            drive(4'b1111, c + 2);
            #1;
            checks++;
            if (bus.dequeue !== exp_deq) begin
                errors++; $display("FAIL rot_dequeue cyc %0d got %b exp %b", c, bus.dequeue, exp_deq);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.grant_idx !== exp_idx) begin
                errors++; $display("FAIL rot_idx cyc %0d got %b exp %b", c, bus.grant_idx, exp_idx);
            end
            checks++;
            if (bus.cdb_out[1] !== mk((c % 2 == 0) ? 1 : 3, c + 2)) begin
                errors++; $display("FAIL rot_cdb1 cyc %0d got %h exp %h", c, bus.cdb_out[1],
                                   mk((c % 2 == 0) ? 1 : 3, c + 2));
            end
            @(negedge clk);
        end
        drive(4'b0000, 0);
    endtask

    task automatic test_single();
        drive(4'b0100, 12);
        #1;
        checks++;
        if (bus.dequeue !== 4'b0100) begin
            errors++; $display("FAIL single_dequeue got %b exp 0100", bus.dequeue);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cdb_out[0] !== mk(2, 12) || bus.cdb_out[1].valid !== 1'b0) begin
            errors++; $display("FAIL single_cdb got %h v1 %b exp %h v1 0", bus.cdb_out[0], bus.cdb_out[1].valid, mk(2, 12));
        end
        checks++;
        if (bus.grant_idx !== 4'b0010 || dut.rr_ptr !== 2'd3) begin
            errors++; $display("FAIL single_idx got %b rr %0d exp 0010 3", bus.grant_idx, dut.rr_ptr);
        end
        @(negedge clk);
        drive(4'b0000, 0);
    endtask

    task automatic test_flush();
        drive(4'b1111, 13);
        #1;
        checks++;
        if (bus.dequeue !== 4'b1001) begin
            errors++; $display("FAIL flush_pre_dequeue got %b exp 1001", bus.dequeue);
        end
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.dequeue !== 4'b0000) begin
            errors++; $display("FAIL flush_dequeue got %b exp 0000", bus.dequeue);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cdb_out[0].valid !== 1'b0 || bus.cdb_out[1].valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid got %b%b exp 00", bus.cdb_out[1].valid, bus.cdb_out[0].valid);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++; $display("FAIL flush_rr got %0d exp 0", dut.rr_ptr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.starve_cnt[i] !== 4'd0) begin
                errors++; $display("FAIL flush_starve %0d got %0d exp 0", i, dut.starve_cnt[i]);
            end
        end
        @(negedge clk);
        bus.flush = 1'b0;
        drive(4'b0000, 0);
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 2; p++) begin
            drive(4'b1111, 14 + p);
            @(posedge clk); #1;
            checks++;
            if (bus.cdb_out[0] !== mk(0, 14 + p)) begin
                errors++; $display("FAIL mid_pending p%0d got %h exp %h", p, bus.cdb_out[0], mk(0, 14 + p));
            end
            @(negedge clk);
            rst       = 1'b1;
            bus.flush = (p == 1);
            #1;
            checks++;
            if (bus.dequeue !== 4'b0000) begin
                errors++; $display("FAIL mid_dequeue p%0d got %b exp 0000", p, bus.dequeue);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.cdb_out !== '0 || bus.grant_idx !== 4'b0000 || dut.rr_ptr !== 2'd0) begin
                errors++; $display("FAIL mid_outputs p%0d got %h idx %b rr %0d exp 0 0 0", p,
                                   bus.cdb_out, bus.grant_idx, dut.rr_ptr);
            end
            @(negedge clk);
            rst       = 1'b0;
            bus.flush = 1'b0;
        end
        drive(4'b0000, 0);
    endtask

    task automatic test_starvation();
        logic [3:0] v_tab   [8];
        logic [3:0] deq_tab [8];
        int         idx_tab [8];
        int         rr_tab  [8];
        v_tab   = '{4'b0111, 4'b0111, 4'b0011, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
        deq_tab = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0010, 4'b0001, 4'b0100, 4'b0010};
        idx_tab = '{0, 1, 0, 2, 1, 0, 2, 1};
        rr_tab  = '{1, 2, 1, 1, 1, 1, 1, 1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive_s(v_tab[c], 20 + c);
            #1;
            checks++;
            if (sbus.dequeue !== deq_tab[c]) begin
                errors++; $display("FAIL starve_dequeue cyc %0d got %b exp %b", c, sbus.dequeue, deq_tab[c]);
            end
            @(posedge clk); #1;
            checks++;
            if (sbus.cdb_out[0] !== mk(idx_tab[c], 20 + c) || sbus.grant_idx !== 2'(idx_tab[c])) begin
                errors++; $display("FAIL starve_cdb cyc %0d got %h idx %0d exp %h idx %0d", c,
                                   sbus.cdb_out[0], sbus.grant_idx, mk(idx_tab[c], 20 + c), idx_tab[c]);
            end
            checks++;
            if (dut_s.rr_ptr !== 2'(rr_tab[c])) begin
                errors++; $display("FAIL starve_rr cyc %0d got %0d exp %0d", c, dut_s.rr_ptr, rr_tab[c]);
            end
            @(negedge clk);
        end
        drive_s(4'b0000, 0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.flush  = 1'b0;
        sbus.flush = 1'b0;
        drive(4'b0000, 0);
        drive_s(4'b0000, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_idle();
        test_two();
        test_rotation();
        test_single();
        test_flush();
        test_reset_mid();
        test_starvation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
